// File: rtl/dm_mmio_bridge.sv
// Data-side bridge behind the CPU MEM stage: passes accesses through to the data SRAM
// or serves a small MMIO window (cycle counter, console TX FIFO, status, sticky halt).
module dm_mmio_bridge #(
  parameter logic [31:0] MMIO_BASE  = 32'h1000_0000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_dm_addr,
  input  logic [31:0] cpu_dm_wdata,
  input  logic [3:0]  cpu_dm_web,
  output logic [31:0] cpu_dm_rdata,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_web,
  input  logic [31:0] ram_rdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        halt,
  output logic [31:0] halt_code
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [5:0] OFF_CYC_LO = 6'h00;
  localparam logic [5:0] OFF_CYC_HI = 6'h01;
  localparam logic [5:0] OFF_TXDATA = 6'h02;
  localparam logic [5:0] OFF_STATUS = 6'h03;
  localparam logic [5:0] OFF_HALT   = 6'h04;

  logic        mmio_sel;
  logic [5:0]  offset;
  logic        wr_any;
  logic [31:0] mmio_rdata;

  logic [63:0]      cycle_reg;
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             overflow_reg;
  logic             halt_reg;
  logic [31:0]      halt_code_reg, halt_code_next;

  logic push_req, push, pop, ovf_set, ovf_clr, halt_wr;
  logic full, empty;

  assign mmio_sel = (cpu_dm_addr[31:8] == MMIO_BASE[31:8]);
  assign offset   = cpu_dm_addr[7:2];
  assign wr_any   = ~&cpu_dm_web;

  assign ram_addr  = cpu_dm_addr;
  assign ram_wdata = cpu_dm_wdata;
  assign ram_web   = mmio_sel ? 4'b1111 : cpu_dm_web;

  assign full  = (count_reg == DEPTH_C);
  assign empty = (count_reg == '0);

  assign pop      = tx_valid && tx_ready;
  assign push_req = mmio_sel && (offset == OFF_TXDATA) && !cpu_dm_web[0];
  // A full FIFO can still take a byte when the head leaves in the same cycle.
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && !push;
  assign ovf_clr  = mmio_sel && (offset == OFF_STATUS) && !cpu_dm_web[2] && cpu_dm_wdata[16];
  assign halt_wr  = mmio_sel && (offset == OFF_HALT) && wr_any && !halt_reg;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_halt_lane
      assign halt_code_next[8*gi +: 8] = cpu_dm_web[gi] ? 8'h00 : cpu_dm_wdata[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_reg     <= '0;
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      halt_reg      <= 1'b0;
      halt_code_reg <= '0;
    end else begin
      if (!halt_reg) cycle_reg <= cycle_reg + 64'd1;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      if (ovf_set)      overflow_reg <= 1'b1;
      else if (ovf_clr) overflow_reg <= 1'b0;
      if (halt_wr) begin
        halt_reg      <= 1'b1;
        halt_code_reg <= halt_code_next;
      end
    end
  end

  // Storage only; validity is tracked by count_reg, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= cpu_dm_wdata[7:0];
  end

  assign tx_valid  = !empty;
  assign tx_data   = tx_valid ? fifo_mem[rd_ptr_reg] : 8'h00;
  assign halt      = halt_reg;
  assign halt_code = halt_code_reg;

  always_comb begin
    mmio_rdata = 32'h0;
    case (offset)
      OFF_CYC_LO: mmio_rdata = cycle_reg[31:0];
      OFF_CYC_HI: mmio_rdata = cycle_reg[63:32];
      OFF_TXDATA: mmio_rdata = {24'h0, tx_data};
      OFF_STATUS: mmio_rdata = {15'h0, overflow_reg, 6'h0, empty, full, 8'(count_reg)};
      OFF_HALT:   mmio_rdata = halt_code_reg;
      default:    mmio_rdata = 32'h0;
    endcase
  end

  assign cpu_dm_rdata = mmio_sel ? mmio_rdata : ram_rdata;

endmodule

// File: tb/tb_dm_mmio_bridge.sv
// Bench for dm_mmio_bridge: a queue-based reference model checked every negedge,
// plus directed stimulus with hand-computed literal expectations.
module tb_dm_mmio_bridge;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 8;
  localparam logic [31:0] A_CYC_LO = BASE + 32'h00;
  localparam logic [31:0] A_TXDATA = BASE + 32'h08;
  localparam logic [31:0] A_STATUS = BASE + 32'h0C;
  localparam logic [31:0] A_HALT   = BASE + 32'h10;
  localparam logic [31:0] A_IDLE   = 32'h0000_0200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cpu_dm_addr = A_IDLE;
  logic [31:0] cpu_dm_wdata = 32'h0;
  logic [3:0]  cpu_dm_web = 4'hF;
  logic [31:0] cpu_dm_rdata;
  logic [31:0] ram_addr, ram_wdata;
  logic [3:0]  ram_web;
  logic [31:0] ram_rdata = 32'hCAFE_0000;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        halt;
  logic [31:0] halt_code;

  int n_checks = 0;
  int n_fail   = 0;

  dm_mmio_bridge dut (
    .clk(clk), .rst(rst),
    .cpu_dm_addr(cpu_dm_addr), .cpu_dm_wdata(cpu_dm_wdata), .cpu_dm_web(cpu_dm_web),
    .cpu_dm_rdata(cpu_dm_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_web(ram_web), .ram_rdata(ram_rdata),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .halt(halt), .halt_code(halt_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0]  m_cyc  = 64'h0;
  bit           m_halt = 1'b0;
  logic [31:0]  m_code = 32'h0;
  bit           m_ovf  = 1'b0;
  byte unsigned m_q[$];
  bit           m_sel, m_pop, m_preq, m_acc, m_clr;
  logic [5:0]   m_off;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc = 64'h0; m_halt = 1'b0; m_code = 32'h0; m_ovf = 1'b0;
      m_q.delete();
    end else begin
      m_sel  = (cpu_dm_addr[31:8] == BASE[31:8]);
      m_off  = cpu_dm_addr[7:2];
      m_pop  = (m_q.size() != 0) && tx_ready;
      m_preq = m_sel && (m_off == 6'd2) && !cpu_dm_web[0];
      m_acc  = m_preq && ((m_q.size() < DEPTH) || m_pop);
      m_clr  = m_sel && (m_off == 6'd3) && !cpu_dm_web[2] && cpu_dm_wdata[16];
      if (!m_halt) m_cyc = m_cyc + 64'd1;
      if (m_sel && (m_off == 6'd4) && (cpu_dm_web != 4'hF) && !m_halt) begin
        m_halt = 1'b1;
        m_code = cpu_dm_wdata & {{8{~cpu_dm_web[3]}}, {8{~cpu_dm_web[2]}},
                                 {8{~cpu_dm_web[1]}}, {8{~cpu_dm_web[0]}}};
      end
      if (m_pop) void'(m_q.pop_front());
      if (m_acc) m_q.push_back(cpu_dm_wdata[7:0]);
      if (m_preq && !m_acc) m_ovf = 1'b1;
      else if (m_clr)       m_ovf = 1'b0;
    end
  end

  function automatic logic [7:0] exp_head();
    return (m_q.size() != 0) ? m_q[0] : 8'h00;
  endfunction

  function automatic logic [31:0] exp_rdata();
    int cnt;
    cnt = m_q.size();
    if (cpu_dm_addr[31:8] != BASE[31:8]) return ram_rdata;
    case (cpu_dm_addr[7:2])
      6'd0: return m_cyc[31:0];
      6'd1: return m_cyc[63:32];
      6'd2: return {24'h0, exp_head()};
      6'd3: return {15'h0, m_ovf, 6'h0, (cnt == 0), (cnt == DEPTH), 8'(cnt)};
      6'd4: return m_code;
      default: return 32'h0;
    endcase
  endfunction

  always @(negedge clk) begin
    check("rdata",     cpu_dm_rdata, exp_rdata());
    check("ram_web",   ram_web, (cpu_dm_addr[31:8] == BASE[31:8]) ? 4'hF : cpu_dm_web);
    check("ram_addr",  ram_addr, cpu_dm_addr);
    check("ram_wdata", ram_wdata, cpu_dm_wdata);
    check("tx_valid",  tx_valid, m_q.size() != 0);
    check("tx_data",   tx_data, exp_head());
    check("halt",      halt, m_halt);
    check("halt_code", halt_code, m_code);
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    cpu_dm_addr  = a;
    cpu_dm_wdata = d;
    cpu_dm_web   = w;
  endtask

  task automatic push(input logic [7:0] b);
    set_bus(A_TXDATA, {24'h0, b}, 4'b1110);
    step();
  endtask

  initial begin
    repeat (2) step();
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data",  tx_data, 8'h00);
    check("rst_halt",     halt, 1'b0);
    rst = 1'b0;

    // Counter: 10 edges after reset release, then an ignored write.
    repeat (10) step();
    set_bus(A_CYC_LO, 32'h0000_FFFF, 4'b0000);
    #3 check("cycle_lo_10", cpu_dm_rdata, 32'd10);
    check("mmio_ram_web", ram_web, 4'hF);
    step();
    set_bus(A_CYC_LO, 32'h0, 4'hF);
    #3 check("cycle_after_wr", cpu_dm_rdata, 32'd11);
    step();

    // RAM pass-through.
    set_bus(32'h0000_0100, 32'h1234_5678, 4'b1100);
    #3 check("ram_store_web", ram_web, 4'b1100);
    check("ram_store_addr", ram_addr, 32'h0000_0100);
    step();
    set_bus(32'h0000_0100, 32'h0, 4'hF);
    ram_rdata = 32'h0000_5678;
    #3 check("ram_load_rdata", cpu_dm_rdata, 32'h0000_5678);
    check("ram_load_web", ram_web, 4'hF);
    step();

    // FIFO ordering under backpressure, then drain.
    push(8'h41); push(8'h42); push(8'h43);
    set_bus(A_STATUS, 32'h0, 4'hF);
    #3 check("status_3", cpu_dm_rdata, 32'h0000_0003);
    check("head_41", tx_data, 8'h41);
    step(); step();
    #3 check("head_41_held", tx_data, 8'h41);
    set_bus(A_IDLE, 32'h0, 4'hF);
    tx_ready = 1'b1;
    #1 check("drain_41", tx_data, 8'h41);
    step();
    #3 check("drain_42", tx_data, 8'h42);
    step();
    #3 check("drain_43", tx_data, 8'h43);
    step();
    #3 check("drain_empty", tx_valid, 1'b0);
    tx_ready = 1'b0;

    // Full and overflow.
    for (int i = 0; i < 9; i++) push(8'h50 + 8'(i));
    set_bus(A_STATUS, 32'h0, 4'hF);
    #3 check("status_full_ovf", cpu_dm_rdata, 32'h0001_0108);
    step();
    set_bus(A_TXDATA, 32'h0000_0060, 4'b1110);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    set_bus(A_STATUS, 32'h0, 4'hF);
    #3 check("status_push_pop_full", cpu_dm_rdata, 32'h0001_0108);
    check("head_after_pop", tx_data, 8'h51);
    step();
    set_bus(A_STATUS, 32'h0001_0000, 4'b0000);
    step();
    set_bus(A_STATUS, 32'h0, 4'hF);
    #3 check("status_ovf_cleared", cpu_dm_rdata, 32'h0000_0108);
    step();

    // Halt.
    set_bus(A_HALT, 32'hDEAD_BEEF, 4'b0000);
    step();
    set_bus(A_IDLE, 32'h0, 4'hF);
    #3 check("halt_set", halt, 1'b1);
    check("halt_code_set", halt_code, 32'hDEAD_BEEF);
    step();
    set_bus(A_HALT, 32'h0000_0001, 4'b0000);
    step();
    set_bus(A_HALT, 32'h0, 4'hF);
    #3 check("halt_code_sticky", cpu_dm_rdata, 32'hDEAD_BEEF);
    step(); step();

    // Drain, load 5 entries, then asynchronous reset mid-cycle.
    set_bus(A_IDLE, 32'h0, 4'hF);
    tx_ready = 1'b1;
    repeat (8) step();
    tx_ready = 1'b0;
    #3 check("drained", tx_valid, 1'b0);
    for (int i = 0; i < 5; i++) push(8'h70 + 8'(i));
    set_bus(A_STATUS, 32'h0, 4'hF);
    #3 check("status_5", cpu_dm_rdata, 32'h0000_0005);
    step();
    set_bus(A_CYC_LO, 32'h0, 4'hF);
    #1 rst = 1'b1;
    #1 check("arst_tx_valid", tx_valid, 1'b0);
    check("arst_tx_data",  tx_data, 8'h00);
    check("arst_halt",     halt, 1'b0);
    check("arst_halt_code", halt_code, 32'h0);
    check("arst_cycle",    cpu_dm_rdata, 32'h0);
    step();
    rst = 1'b0;
    repeat (3) step();
    #3 check("cycle_after_rerelease", cpu_dm_rdata, 32'd3);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
